// File: rtl/cover_pkg.sv
// rtl/cover_pkg.sv - shared types and helpers for the toggle cover reporters and collector
package cover_pkg;

  localparam int COVER_INDEX_W = 64;

  typedef logic [COVER_INDEX_W-1:0] cover_index_t;

  // Bits needed to hold the values 0..width inclusive.
  function automatic int clog2_w(input int width);
    int w;
    w = 0;
    for (int b = 0; b < 31; b++) begin
      if ((1 << b) < (width + 1)) w = b + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cover_prio_enc.sv
// rtl/cover_prio_enc.sv - lowest-set-bit finder used to pick the next cover point to report
module cover_prio_enc #(
  parameter int WIDTH = 44,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] pending,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan from the top so the last assignment wins with the lowest set bit.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cover_toggle_collector.sv
// rtl/cover_toggle_collector.sv - sticky toggle-coverage bitmap that streams each first hit once as a global index
module cover_toggle_collector
  import cover_pkg::*;
#(
  parameter int           WIDTH       = 44,
  parameter cover_index_t COVER_INDEX = '0,
  parameter int           COVER_TOTAL = 0,
  localparam int          HC_W        = clog2_w(WIDTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   valid,
  input  logic               clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        out_index,
  output logic [HC_W-1:0]    hit_count,
  output logic               all_hit
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
    $error("cover_toggle_collector: WIDTH out of range");
  end
  if (COVER_TOTAL != 0 && COVER_TOTAL < WIDTH) begin : g_bad_total
    $error("cover_toggle_collector: COVER_TOTAL smaller than WIDTH");
  end

  logic [WIDTH-1:0] covered_q, covered_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] pending_eff;
  logic [WIDTH-1:0] load_mask;
  logic             out_valid_q, out_valid_d;
  cover_index_t     out_index_q, out_index_d;
  logic [HC_W-1:0]  hit_count_q, hit_count_d;
  logic             all_hit_q, all_hit_d;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_found;
  logic             stage_free;

  // A clearing cycle must not launch anything still pending from before the clear.
  assign pending_eff = clear ? '0 : pending_q;
  assign stage_free  = !out_valid_q || out_ready;
  assign load_mask   = (stage_free && enc_found) ? (WIDTH'(1) << enc_idx) : '0;

  cover_prio_enc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .pending (pending_eff),
    .idx     (enc_idx),
    .found   (enc_found)
  );

  always_comb begin
    covered_d   = covered_q;
    pending_d   = pending_q;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    hit_count_d = '0;
    if (clear) begin
      covered_d = '0;
      pending_d = '0;
    end else begin
      covered_d = covered_q | valid;
      pending_d = (pending_q | (valid & ~covered_q)) & ~load_mask;
    end
    if (stage_free) begin
      out_valid_d = enc_found;
      if (enc_found) out_index_d = COVER_INDEX + cover_index_t'(enc_idx);
    end
    for (int i = 0; i < WIDTH; i++) begin
      hit_count_d = hit_count_d + HC_W'(covered_d[i]);
    end
    all_hit_d = &covered_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      covered_q   <= '0;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      hit_count_q <= '0;
      all_hit_q   <= 1'b0;
    end else begin
      covered_q   <= covered_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      hit_count_q <= hit_count_d;
      all_hit_q   <= all_hit_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign hit_count = hit_count_q;
  assign all_hit   = all_hit_q;

endmodule
